// File: rtl/mem_block_mover.sv
// mem_block_mover: bus initiator that copies (src -> dst) or fills (fill_val -> dst)
// a block of 32-bit words through a single-port data-memory interface.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               one-cycle request, accepted only in IDLE
//   mode                0 = copy, 1 = fill (sampled with start)
//   src, dst            byte addresses (sampled with start)
//   len                 word count (sampled with start)
//   fill_val            fill pattern (sampled with start)
//   busy                high from the cycle after acceptance through DONE
//   done                one-cycle completion/abort pulse
//   err                 sticky abort flag, cleared by the next accepted start
//   words_done          words written so far in the current block
//   mem_rd, mem_wr      memory strobes (never both high)
//   mem_addr, mem_wdata memory address / write data
//   mem_rdata           combinational read data from memory
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; memory port released (all outputs 0)
// CHECK  | alignment and zero-length screening of the latched operands
// READ   | copy only: read one source word into the buffer
// WRITE  | write one word (buffer or fill pattern), advance pointers
// DONE   | one-cycle done pulse, then back to IDLE

module mem_block_mover #(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [31:0]         src,
    input  logic [31:0]         dst,
    input  logic [LEN_BITS-1:0] len,
    input  logic [31:0]         fill_val,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [LEN_BITS-1:0] words_done,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic                mode_q;
    logic [31:0]         cur_src, cur_dst, fill_q, buf_q;
    logic [LEN_BITS-1:0] remaining;
    logic                err_q;
    logic [LEN_BITS-1:0] words_done_q;

    logic load, set_err, capture, advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            cur_src      <= '0;
            cur_dst      <= '0;
            fill_q       <= '0;
            buf_q        <= '0;
            remaining    <= '0;
            err_q        <= 1'b0;
            words_done_q <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                mode_q       <= mode;
                cur_src      <= src;
                cur_dst      <= dst;
                fill_q       <= fill_val;
                remaining    <= len;
                err_q        <= 1'b0;
                words_done_q <= '0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (capture) begin
                buf_q <= mem_rdata;
            end
            if (advance) begin
                words_done_q <= words_done_q + LEN_BITS'(1);
                remaining    <= remaining - LEN_BITS'(1);
                cur_dst      <= cur_dst + 32'd4;
                if (!mode_q) begin
                    cur_src <= cur_src + 32'd4;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        set_err   = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cur_dst[1:0] != 2'b00 || (!mode_q && cur_src[1:0] != 2'b00)) begin
                    set_err = 1'b1;
                    state_n = S_DONE;
                end else if (remaining == '0) begin
                    state_n = S_DONE;
                end else begin
                    state_n = mode_q ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                // Peripheral space is never touched: abort before strobing.
                if (cur_src[31:28] == 4'h4) begin
                    set_err = 1'b1;
                    state_n = S_DONE;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = cur_src;
                    capture  = 1'b1;
                    state_n  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cur_dst[31:28] == 4'h4) begin
                    set_err = 1'b1;
                    state_n = S_DONE;
                end else begin
                    mem_wr    = 1'b1;
                    mem_addr  = cur_dst;
                    mem_wdata = mode_q ? fill_q : buf_q;
                    advance   = 1'b1;
                    if (remaining == LEN_BITS'(1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = mode_q ? S_WRITE : S_READ;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Testbench for mem_block_mover: memory responder, behavioural reference model
// that predicts the access stream and completion, and a decoupled scoreboard.

module tb_mem_block_mover;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic [31:0] fill_val = '0;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    mem_block_mover #(.LEN_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder and the reference model's own view of memory.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] rrd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_rd && mem_addr[31:28] != 4'h4) mem_rdata = mrd(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_wr && mem_addr[31:28] != 4'h4) mem[mem_addr] = mem_wdata;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard queues
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    typedef struct {
        bit err;
        int words;
        int lat;
    } cmp_t;

    acc_t exp_acc[$];
    cmp_t exp_done[$];

    // Reference model: walks the block word by word, applying the alignment,
    // zero-length and peripheral-region rules, and predicts every access.
    function automatic bit model(input bit m, input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] l, input logic [31:0] f);
        int   cyc = 0;
        int   n = 0;
        bit   e = 0;
        acc_t a;
        cmp_t c;
        if (d[1:0] != 2'b00 || (!m && s[1:0] != 2'b00)) begin
            e = 1;
        end else begin
            for (int i = 0; i < int'(l); i++) begin
                logic [31:0] sa, da, v;
                sa = s + 32'(4 * i);
                da = d + 32'(4 * i);
                v  = f;
                if (!m) begin
                    cyc++;
                    if (sa[31:28] == 4'h4) begin e = 1; break; end
                    a.wr = 0; a.addr = sa; a.data = '0;
                    exp_acc.push_back(a);
                    v = rrd(sa);
                end
                cyc++;
                if (da[31:28] == 4'h4) begin e = 1; break; end
                a.wr = 1; a.addr = da; a.data = v;
                exp_acc.push_back(a);
                ref_mem[da] = v;
                n++;
            end
        end
        c.err = e; c.words = n; c.lat = cyc + 2;
        exp_done.push_back(c);
        return e;
    endfunction

    // Monitor: compares each strobe and each done pulse against the queues.
    int   ncyc = 0;
    int   start_neg = 0;
    int   last_lat = -1;
    acc_t mon_a;
    cmp_t mon_c;

    always @(negedge clk) begin
        ncyc++;
        if (!reset && start && !busy) start_neg = ncyc;
        if (mem_rd || mem_wr) begin
            if (exp_acc.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_access: got rd=%0b wr=%0b addr %0h expected no strobe",
                         mem_rd, mem_wr, mem_addr);
            end else begin
                mon_a = exp_acc.pop_front();
                chk("strobe_kind", {mem_rd, mem_wr}, mon_a.wr ? 2'b01 : 2'b10);
                chk("mem_addr", mem_addr, mon_a.addr);
                if (mon_a.wr) chk("mem_wdata", mem_wdata, mon_a.data);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                mon_c = exp_done.pop_front();
                last_lat = ncyc - start_neg;
                chk("done_err", err, mon_c.err);
                chk("done_words", words_done, mon_c.words);
                chk("done_latency", last_lat, mon_c.lat);
                chk("done_busy", busy, 1'b1);
            end
        end
    end

    task automatic run_op(input bit m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [31:0] f, input bit poke);
        bit e;
        bit got = 0;
        e = model(m, s, d, l, f);
        @(posedge clk); #1;
        start = 1; mode = m; src = s; dst = d; len = l; fill_val = f;
        @(posedge clk); #1;
        start = 0;
        mode = ~m; src = $urandom; dst = $urandom; len = 16'($urandom); fill_val = $urandom;
        for (int i = 0; i < 2 * int'(l) + 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else start = (poke && i == 1);
        end
        start = 0;
        chk("done_seen", got, 1'b1);
        @(negedge clk);
        chk("err_sticky", err, e);
        chk("idle_busy", busy, 1'b0);
        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        exp_acc.delete();
        exp_done.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a;
        logic [31:0] s, d;
        bit m;

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_outputs",
            {busy, done, err, words_done, mem_rd, mem_wr, mem_addr, mem_wdata},
            '0);

        // Copy of four words, with an ignored start pulse while busy.
        for (int i = 0; i < 4; i++) preload(32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
        run_op(0, 32'h10, 32'h100, 16'd4, 32'h0, 1);
        chk("copy_latency", last_lat, 10);
        for (int i = 0; i < 4; i++) chk("copy_data", mrd(32'h100 + 32'(4 * i)), 32'hA0 + 32'(i));
        chk("copy_words", words_done, 16'd4);

        // Fill of three words.
        run_op(1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF, 0);
        chk("fill_latency", last_lat, 5);
        chk("fill_data", mrd(32'h48), 32'hDEADBEEF);

        // Copy running into peripheral space.
        preload(32'h3FFFFFF8, 32'h5555AAAA);
        preload(32'h3FFFFFFC, 32'h12345678);
        run_op(0, 32'h3FFFFFF8, 32'h0, 16'd4, 32'h0, 0);
        chk("region_err", err, 1'b1);
        chk("region_words", words_done, 16'd2);
        chk("region_data", mrd(32'h4), 32'h12345678);

        // Misaligned destination, then zero length (err cleared by new start).
        run_op(1, 32'h0, 32'h102, 16'd2, 32'h1, 0);
        chk("misalign_latency", last_lat, 2);
        run_op(0, 32'h200, 32'h300, 16'd0, 32'h0, 0);
        chk("zero_len_err", err, 1'b0);

        // Overlapping forward copy propagates the first word.
        preload(32'h20, 32'h11);
        run_op(0, 32'h20, 32'h24, 16'd3, 32'h0, 0);
        for (int i = 1; i <= 3; i++) chk("overlap_data", mrd(32'h20 + 32'(4 * i)), 32'h11);

        // Fill wrapping past the top of the address space.
        run_op(1, 32'h0, 32'hFFFFFFF8, 16'd4, 32'hCAFEF00D, 0);
        chk("wrap_data", mrd(32'h4), 32'hCAFEF00D);

        // Reset during the WRITE of word 2 of 8.
        a.wr = 1; a.data = 32'h0BADF00D;
        a.addr = 32'h600; exp_acc.push_back(a);
        a.addr = 32'h604; exp_acc.push_back(a);
        ref_mem[32'h600] = a.data;
        ref_mem[32'h604] = a.data;
        @(posedge clk); #1;
        start = 1; mode = 1; dst = 32'h600; len = 16'd8; fill_val = 32'h0BADF00D;
        @(posedge clk); #1 start = 0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_words", words_done, 16'd0);
        repeat (12) @(negedge clk);
        chk("rst_acc_drained", exp_acc.size(), 0);
        chk("rst_word2_written", mrd(32'h604), 32'h0BADF00D);
        chk("rst_word3_untouched", mrd(32'h608), 32'h0);
        exp_acc.delete();

        // Randomized operations in a small window so blocks overlap often.
        for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(4 * i), $urandom);
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom_range(0, 1));
            s = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            d = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 9) == 0) d[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) s[1:0] = 2'($urandom_range(1, 3));
            run_op(m, s, d, 16'($urandom_range(0, 12)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 80; i++)
            chk("final_mem", mrd(32'h1000 + 32'(4 * i)), rrd(32'h1000 + 32'(4 * i)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus-initiator that copies or fills a block of 32-bit words through a single-port data-memory interface.
- Responder-side timing of that interface:
  - `rdata` is combinational from `rd`/`addr` in the same cycle.
  - A write commits at the posedge while `wr` is high.
  - The responder ignores any access whose `addr[31:28]==4'h4` (peripheral space).
- Sits beside the CPU. CPU-side registers program it; while busy it owns the data-memory port.

Parameters:
- LEN_BITS, 16, width of word-count operand and progress counter.

Ports:
- `clk`  input  1  system clock, all logic on posedge.
- `reset`  input  1  synchronous, active-high reset; sampled on posedge `clk`.
- `start`  input  1  one-cycle request; accepted only in IDLE.
- `mode`  input  1  0 = copy (`src`→`dst`), 1 = fill (`fill_val`→`dst`); sampled with `start`.
- `src`  input  32  source byte address, sampled with `start`.
- `dst`  input  32  destination byte address, sampled with `start`.
- `len`  input  LEN_BITS  number of words, sampled with `start`.
- `fill_val`  input  32  fill pattern, sampled with `start`.
- `busy`  output  1  high from the cycle after acceptance until DONE is exited.
- `done`  output  1  one-cycle pulse at completion or abort.
- `err`  output  1  sticky abort flag; cleared by the next accepted `start`.
- `words_done`  output  LEN_BITS  count of words written so far.
- `mem_rd`  output  1  read strobe to data memory.
- `mem_wr`  output  1  write strobe to data memory.
- `mem_addr`  output  32  word-aligned byte address.
- `mem_wdata`  output  32  write data.
- `mem_rdata`  input  32  read data, valid combinationally in the same cycle as `mem_rd`/`mem_addr`.

Behaviour:
- Reset values (synchronous, `reset`=1 at posedge):
  - State IDLE; all internal address, count and buffer registers cleared.
  - `busy`=0, `done`=0, `err`=0, `words_done`=0.
  - `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
  - Reset overrides any in-flight transfer. No further memory strobes follow; the partially written block is left as is.
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE:
  - `start`=1 → latch operands, clear `err` and `words_done`, go to CHECK.
  - `start` in any other state is ignored, with no side effect.
- CHECK (1 cycle):
  - Abort (`err`←1, go to DONE) if `dst[1:0]`≠0, or if `mode`=0 and `src[1:0]`≠0.
  - Otherwise, if `len`=0 → DONE with `err`=0.
  - Otherwise go to READ if `mode`=0, or WRITE if `mode`=1.
- READ (copy only, 1 cycle per word):
  - If `cur_src[31:28]`==4'h4 → abort: `err`←1, DONE, no strobe issued.
  - Otherwise drive `mem_rd`=1, `mem_addr`=`cur_src`; capture `mem_rdata` into the word buffer at the posedge; go to WRITE.
- WRITE (1 cycle per word):
  - If `cur_dst[31:28]`==4'h4 → abort: `err`←1, DONE, no strobe issued.
  - Otherwise drive `mem_wr`=1, `mem_addr`=`cur_dst`, `mem_wdata` = buffer (copy) or `fill_val` (fill).
  - At the posedge:
    - `words_done`+1.
    - `cur_dst`+4 and, for copy, `cur_src`+4.
    - Remaining count −1.
    - Remaining now 0 → DONE; else READ (copy) or WRITE (fill).
- DONE (1 cycle): `done`=1, `busy`=1; then IDLE. `err` holds its value until the next accepted `start`.
- Strobe rules:
  - `mem_rd` and `mem_wr` are never high in the same cycle.
  - Both strobes are 0 in IDLE, CHECK and DONE.
  - `mem_addr` and `mem_wdata` are don't-care when no strobe is active, but drive 0 in IDLE.
- Throughput: copy takes 2 cycles per word, fill takes 1 cycle per word, plus 2 cycles overhead (CHECK and DONE).
- Address arithmetic:
  - 32-bit modulo-2^32; wrap past 0xFFFFFFFC is permitted.
  - The per-word region check catches entry into the 0x4xxxxxxx region mid-block.
- Overlap: a copy with `src`<`dst`<`src`+4·`len` is defined as a strict forward word-by-word copy, so earlier written words propagate. This is intended, not an error.
- `words_done` is LEN_BITS wide and never exceeds `len`.

Test Plan:
- Copy, `src`=0x00000010, `dst`=0x00000100, `len`=4, memory preloaded with 0xA0..0xA3:
  - `done` pulses exactly 10 cycles after `start`.
  - 0x100..0x10C = 0xA0..0xA3; `words_done`=4; `err`=0.
  - `mem_rd` and `mem_wr` alternate and never overlap.
- Fill, `dst`=0x00000040, `len`=3, `fill_val`=0xDEADBEEF:
  - Three consecutive `mem_wr` cycles at 0x40, 0x44, 0x48.
  - `done` pulses 5 cycles after `start`.
- Abort on region: copy `src`=0x3FFFFFF8, `dst`=0x00000000, `len`=4:
  - Two words copied, then READ at 0x40000000 issues no strobe.
  - `err`=1, `words_done`=2, `done` pulses.
- Misaligned and zero length:
  - `dst`=0x00000102 → `err`=1, zero strobes, `done` 2 cycles after `start`.
  - `len`=0 with aligned operands → `err`=0, zero strobes.
- Ignored start and reset mid-transfer:
  - `start` pulsed while busy changes nothing.
  - `reset`=1 during WRITE of word 2 of 8: next cycle `busy`=0, `mem_wr`=0, `words_done`=0, and no further writes occur.
- Overlapping forward copy, `src`=0x20, `dst`=0x24, `len`=3, 0x20 preloaded with 0x11: 0x24, 0x28 and 0x2C all become 0x11.
